// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_DATA_BITS = 8;

    // True when the data byte plus its parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-flop synchronizer, FILTER_LEN-sample glitch filter and a
// registered falling-edge strobe on the filtered level.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The bus idles high, so everything presets to 1 and no edge fires out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync2;
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: frames bytes and folds F0/E0 prefixes into flags.
// Optional frame timeout is compiled in with `define PS2_RX_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | next edge carries the odd-parity bit
// STOP   | next edge carries the stop bit; frame is evaluated on it
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    ps2_state_t state;
    ps2_state_t state_next;

    logic       clk_fall;
    logic       data_lvl;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic       par_bit;
    logic       pending_break;
    logic       pending_ext;
    logic       timeout_hit;

    logic       ev_valid;
    logic       ev_perr;
    logic       ev_ferr;
    logic       set_brk;
    logic       set_ext;
    logic       clr_pend;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_clk),
        .level (),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_data),
        .level (data_lvl),
        .fall  ()
    );

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset || clk_fall || state == IDLE) begin
            to_cnt <= '0;
        end else if (!timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A real edge in the same cycle wins over the timeout.
    assign timeout_hit = (state != IDLE) && !clk_fall && (to_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (clk_fall) begin
            case (state)
                IDLE:    if (!data_lvl) state_next = DATA;
                DATA:    if (bitcnt == 3'(PS2_DATA_BITS - 1)) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ev_valid = 1'b0;
        ev_perr  = 1'b0;
        ev_ferr  = 1'b0;
        set_brk  = 1'b0;
        set_ext  = 1'b0;
        clr_pend = 1'b0;
        if (timeout_hit) begin
            ev_ferr  = 1'b1;
            clr_pend = 1'b1;
        end else if (clk_fall && state == STOP) begin
            // data_lvl here is the stop bit itself.
            if (!data_lvl) begin
                ev_ferr  = 1'b1;
                clr_pend = 1'b1;
            end else if (!odd_parity_ok(shreg, par_bit)) begin
                ev_perr  = 1'b1;
                clr_pend = 1'b1;
            end else if (shreg == PS2_BREAK) begin
                set_brk = 1'b1;
            end else if (shreg == PS2_EXT) begin
                set_ext = 1'b1;
            end else begin
                ev_valid = 1'b1;
                clr_pend = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt        <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            pending_break <= 1'b0;
            pending_ext   <= 1'b0;
            scan_code     <= '0;
            code_valid    <= 1'b0;
            is_break      <= 1'b0;
            is_extended   <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            code_valid <= ev_valid;
            parity_err <= ev_perr;
            frame_err  <= ev_ferr;

            if (ev_valid) begin
                scan_code   <= shreg;
                is_break    <= pending_break;
                is_extended <= pending_ext;
            end

            if (clr_pend) begin
                pending_break <= 1'b0;
                pending_ext   <= 1'b0;
            end else begin
                if (set_brk) pending_break <= 1'b1;
                if (set_ext) pending_ext   <= 1'b1;
            end

            if (clk_fall && !timeout_hit) begin
                case (state)
                    IDLE: bitcnt <= '0;
                    DATA: begin
                        shreg[bitcnt] <= data_lvl;
                        bitcnt        <= bitcnt + 1'b1;
                    end
                    PARITY:  par_bit <= data_lvl;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx; define PS2_RX_TIMEOUT_EN to also exercise the timeout.
module tb_ps2_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int HALF           = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         n_valid = 0;
    int         n_perr  = 0;
    int         n_ferr  = 0;
    int         n_wide  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_code = '0;
    logic       last_brk  = 1'b0;
    logic       last_ext  = 1'b0;

    int v0, p0, f0;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .code_valid  (code_valid),
        .is_break    (is_break),
        .is_extended (is_extended),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) begin
            n_valid++;
            last_code = scan_code;
            last_brk  = is_break;
            last_ext  = is_extended;
            if (prev_valid) n_wide++;
        end
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        prev_valid = code_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Sends the first nbits of a frame; data changes only while ps2_clk is high.
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            cycles(HALF / 2);
            ps2_clk = 1'b0;
            cycles(HALF);
            ps2_clk = 1'b1;
            cycles(HALF / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic snap();
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cycles(5);
        @(negedge clk);
        chk("rst_scan_code", 32'(scan_code), 32'h0);
        chk("rst_code_valid", 32'(code_valid), 32'h0);
        chk("rst_flags", 32'({is_break, is_extended}), 32'h0);
        chk("rst_errs", 32'({parity_err, frame_err}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        reset = 1'b0;
        cycles(20);

        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        cycles(10);
        chk("make_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("make_code", 32'(last_code), 32'h1C);
        chk("make_flags", 32'({last_brk, last_ext}), 32'h0);
        chk("make_hold", 32'(scan_code), 32'h1C);

        snap();
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        cycles(10);
        chk("f0_no_valid", 32'(n_valid - v0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        cycles(10);
        chk("brk_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("brk_code", 32'(last_code), 32'h1C);
        chk("brk_flags", 32'({last_brk, last_ext}), 32'b10);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        cycles(10);
        chk("after_brk_flags", 32'({last_brk, last_ext}), 32'b00);

        snap();
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        send_frame(8'h75, 1'b0, 1'b1, 11);
        cycles(10);
        chk("ext_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("ext_code", 32'(last_code), 32'h75);
        chk("ext_flags", 32'({last_brk, last_ext}), 32'b11);

        snap();
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        cycles(10);
        chk("par_err_cnt", 32'(n_perr - p0), 32'd1);
        chk("par_no_valid", 32'(n_valid - v0), 32'd0);
        chk("par_no_ferr", 32'(n_ferr - f0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        cycles(10);
        chk("par_pend_clr", 32'({last_code, last_brk, last_ext}), {22'd0, 8'h1C, 2'b00});

        snap();
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        cycles(10);
        chk("stop_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        chk("stop_no_valid", 32'(n_valid - v0), 32'd0);
        chk("stop_no_perr", 32'(n_perr - p0), 32'd0);
        send_frame(8'h29, 1'b0, 1'b1, 11);
        cycles(10);
        chk("stop_pend_clr", 32'({last_code, last_brk, last_ext}), {22'd0, 8'h29, 2'b00});

        snap();
        send_frame(8'h16, 1'b0, 1'b1, 11);
        send_frame(8'h1E, 1'b0, 1'b1, 11);
        cycles(10);
        chk("b2b_valid_cnt", 32'(n_valid - v0), 32'd2);
        chk("b2b_code", 32'(last_code), 32'h1E);

        ps2_data = 1'b0;
        cycles(30);
        ps2_clk = 1'b0;
        cycles(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        cycles(30);
        @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'h0);
        ps2_data = 1'b1;
        cycles(30);

        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        @(posedge clk);
        reset = 1'b1;
        cycles(3);
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_code", 32'(scan_code), 32'h0);
        @(posedge clk);
        reset = 1'b0;
        cycles(20);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        cycles(10);
        chk("mid_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("mid_code", 32'(last_code), 32'h1C);
        chk("mid_no_errs", 32'((n_perr - p0) + (n_ferr - f0)), 32'd0);

`ifdef PS2_RX_TIMEOUT_EN
        snap();
        send_frame(8'h00, 1'b0, 1'b1, 5);
        cycles(TIMEOUT_CYCLES + 200);
        @(negedge clk);
        chk("to_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_no_valid", 32'(n_valid - v0), 32'd0);
        send_frame(8'h29, 1'b0, 1'b1, 11);
        cycles(10);
        chk("to_next_code", 32'(last_code), 32'h29);
`endif

        chk("pulse_width", 32'(n_wide), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
